// File: rtl/rx_shift_hold_reg.sv
// ---------------------------------------------------------------------------
// rx_shift_hold_reg
//   Receive shift/hold register for a UTMI-style receiver. It consumes the
//   recovered serial bit stream after NRZI decode and bit unstuffing, one bit
//   per bit_valid strobe. It hunts for SYNC, deserializes LSB-first bytes into
//   a hold register, and reports EOP and receive errors.
//
//   Optional feature macro: RX_DRIBBLE_EN
//     When defined, a single dribble bit (bit_cnt == 1) at EOP is dropped
//     silently instead of being reported as a partial-byte error.
//
// Ports
//   Clk           system clock, rising edge
//   Rst           asynchronous active-low reset
//   rx_enable     receiver enable; low forces IDLE and clears status outputs
//   bit_valid     strobe qualifying data_in_s / se0 / stuff_bit / stuff_err
//   data_in_s     decoded serial data bit
//   stuff_bit     current strobed bit is a stuffed bit (dropped)
//   stuff_err     bit-stuff violation from the unstuff stage
//   se0           line is SE0 on this strobe (overrides data_in_s)
//   DataOut       received byte hold register
//   RxValid       one-cycle pulse: DataOut holds a new byte
//   RxActive      high from SYNC detect until EOP / abort
//   sync_detected one-cycle pulse on SYNC match
//   EOP_detected  one-cycle pulse on EOP
//   RxError       one-cycle pulse on stuff error, bad EOP or partial byte
//   rx_state      debug view of the receive state (IDLE=0 HUNT=1 DATA=2
//                 EOP=3 ERR=4)
//
// Handshake: there is no backpressure. Every input is sampled only on a
// cycle with bit_valid high; every status output is registered and its pulse
// appears in the cycle after the strobe that caused it.
// ---------------------------------------------------------------------------
module rx_shift_hold_reg #(
    parameter logic [7:0] SYNC_PATTERN = 8'h80,
    parameter int         EOP_SE0_BITS = 2
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       rx_enable,
    input  logic       bit_valid,
    input  logic       data_in_s,
    input  logic       stuff_bit,
    input  logic       stuff_err,
    input  logic       se0,
    output logic [7:0] DataOut,
    output logic       RxValid,
    output logic       RxActive,
    output logic       sync_detected,
    output logic       EOP_detected,
    output logic       RxError,
    output logic [2:0] rx_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HUNT = 3'd1,
        S_DATA = 3'd2,
        S_EOP  = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    localparam logic [1:0] EOP_MIN = 2'(EOP_SE0_BITS);

    state_t     state;
    logic [7:0] sh;
    logic [2:0] bit_cnt;
    logic [1:0] se0_cnt;
    logic [4:0] hunt_cnt;
    logic       err_seen;   // packet already reported an error before EOP

    logic       accepted;
    logic       se0_strobe;
    logic [7:0] sh_next;
    logic       se0_long;
    logic       dribble_ok;

    assign accepted   = bit_valid & ~se0 & ~stuff_bit;
    assign se0_strobe = bit_valid & se0;
    assign sh_next    = {data_in_s, sh[7:1]};
    assign se0_long   = (se0_cnt >= EOP_MIN);
    assign rx_state   = state;

`ifdef RX_DRIBBLE_EN
    assign dribble_ok = (bit_cnt == 3'd1);
`else
    assign dribble_ok = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state         <= S_IDLE;
            sh            <= 8'h00;
            bit_cnt       <= 3'd0;
            se0_cnt       <= 2'd0;
            hunt_cnt      <= 5'd0;
            err_seen      <= 1'b0;
            DataOut       <= 8'h00;
            RxValid       <= 1'b0;
            RxActive      <= 1'b0;
            sync_detected <= 1'b0;
            EOP_detected  <= 1'b0;
            RxError       <= 1'b0;
        end else begin
            // pulses default low every cycle
            RxValid       <= 1'b0;
            sync_detected <= 1'b0;
            EOP_detected  <= 1'b0;
            RxError       <= 1'b0;

            if (!rx_enable) begin
                // silent abort: no EOP/error reporting, DataOut is kept
                state    <= S_IDLE;
                RxActive <= 1'b0;
                sh       <= 8'h00;
                bit_cnt  <= 3'd0;
                se0_cnt  <= 2'd0;
                hunt_cnt <= 5'd0;
                err_seen <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        // the first 0 starts the hunt; it is the first SYNC bit
                        if (accepted && !data_in_s) begin
                            state    <= S_HUNT;
                            sh       <= 8'h00;
                            hunt_cnt <= 5'd0;
                        end
                    end

                    S_HUNT: begin
                        if (se0_strobe) begin
                            state <= S_IDLE;
                        end else if (accepted) begin
                            sh <= sh_next;
                            if (sh_next == SYNC_PATTERN) begin
                                state         <= S_DATA;
                                sync_detected <= 1'b1;
                                RxActive      <= 1'b1;
                                bit_cnt       <= 3'd0;
                                err_seen      <= 1'b0;
                            end else if (hunt_cnt == 5'd16) begin
                                // 17th bit in HUNT without a match
                                state <= S_IDLE;
                            end else begin
                                hunt_cnt <= hunt_cnt + 5'd1;
                            end
                        end
                    end

                    S_DATA: begin
                        // stuff_err overrides a coincident stuff_bit or se0
                        if (bit_valid && stuff_err) begin
                            state   <= S_ERR;
                            RxError <= 1'b1;
                        end else if (se0_strobe) begin
                            // SE0 wins over a byte-completing bit
                            state   <= S_EOP;
                            se0_cnt <= 2'd1;
                        end else if (accepted) begin
                            sh      <= sh_next;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                DataOut <= sh_next;
                                RxValid <= 1'b1;
                            end
                        end
                    end

                    S_ERR: begin
                        // data ignored until the line goes SE0
                        if (se0_strobe) begin
                            state    <= S_EOP;
                            se0_cnt  <= 2'd1;
                            err_seen <= 1'b1;
                        end
                    end

                    S_EOP: begin
                        if (se0_strobe) begin
                            if (se0_cnt != 2'd3) se0_cnt <= se0_cnt + 2'd1;
                        end else if (bit_valid) begin
                            // first J after SE0 closes the packet
                            state    <= S_IDLE;
                            RxActive <= 1'b0;
                            se0_cnt  <= 2'd0;
                            bit_cnt  <= 3'd0;
                            err_seen <= 1'b0;
                            if (err_seen) begin
                                // error already reported: exit without RxError
                                if (se0_long) EOP_detected <= 1'b1;
                            end else if (!se0_long) begin
                                RxError <= 1'b1;
                            end else if (bit_cnt == 3'd0 || dribble_ok) begin
                                EOP_detected <= 1'b1;
                            end else begin
                                EOP_detected <= 1'b1;
                                RxError      <= 1'b1;
                            end
                        end
                    end

                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rx_shift_hold_reg.sv
module tb_rx_shift_hold_reg;

    logic       Clk;
    logic       Rst;
    logic       rx_enable;
    logic       bit_valid;
    logic       data_in_s;
    logic       stuff_bit;
    logic       stuff_err;
    logic       se0;
    logic [7:0] DataOut;
    logic       RxValid;
    logic       RxActive;
    logic       sync_detected;
    logic       EOP_detected;
    logic       RxError;
    logic [2:0] rx_state;

    int n_checks = 0;
    int n_fail   = 0;
    int n_valid, n_sync, n_eop, n_err;

    rx_shift_hold_reg dut (
        .Clk(Clk), .Rst(Rst), .rx_enable(rx_enable), .bit_valid(bit_valid),
        .data_in_s(data_in_s), .stuff_bit(stuff_bit), .stuff_err(stuff_err),
        .se0(se0), .DataOut(DataOut), .RxValid(RxValid), .RxActive(RxActive),
        .sync_detected(sync_detected), .EOP_detected(EOP_detected),
        .RxError(RxError), .rx_state(rx_state)
    );

    // clock / reset block
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // driver tasks
    task automatic clear_counts();
        n_valid = 0; n_sync = 0; n_eop = 0; n_err = 0;
    endtask

    task automatic sample();
        n_valid += int'(RxValid);
        n_sync  += int'(sync_detected);
        n_eop   += int'(EOP_detected);
        n_err   += int'(RxError);
    endtask

    task automatic strobe(input logic d, input logic s0, input logic stf, input logic er);
        @(negedge Clk);
        bit_valid = 1'b1; data_in_s = d; se0 = s0; stuff_bit = stf; stuff_err = er;
        @(posedge Clk);
        #1;
        bit_valid = 1'b0; se0 = 1'b0; stuff_bit = 1'b0; stuff_err = 1'b0;
        sample();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge Clk);
            @(posedge Clk);
            #1;
            sample();
        end
    endtask

    task automatic send_bit(input logic d);
        strobe(d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_se0();
        strobe(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic send_sync();
        for (int i = 0; i < 7; i++) send_bit(1'b0);
        send_bit(1'b1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
    endtask

    // scenarios
    task automatic test_reset();
        n_checks++;
        if ({DataOut, RxValid, RxActive, sync_detected, EOP_detected, RxError} !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, expected 0",
                     {DataOut, RxValid, RxActive, sync_detected, EOP_detected, RxError});
        end
        n_checks++;
        if (rx_state !== 3'd0) begin
            n_fail++; $display("FAIL reset_state: got %0d, expected 0", rx_state);
        end
    endtask

    task automatic test_sync();
        clear_counts();
        for (int i = 0; i < 7; i++) send_bit(1'b0);
        n_checks++;
        if (n_sync !== 0 || RxActive !== 1'b0) begin
            n_fail++; $display("FAIL sync_early: sync=%0d active=%b, expected 0/0", n_sync, RxActive);
        end
        send_bit(1'b1);
        n_checks++;
        if (sync_detected !== 1'b1 || RxActive !== 1'b1) begin
            n_fail++; $display("FAIL sync_pulse: sync=%b active=%b, expected 1/1", sync_detected, RxActive);
        end
        idle(1);
        n_checks++;
        if (sync_detected !== 1'b0 || RxActive !== 1'b1) begin
            n_fail++; $display("FAIL sync_one_cycle: sync=%b active=%b, expected 0/1", sync_detected, RxActive);
        end
    endtask

    task automatic test_bytes();
        clear_counts();
        send_byte(8'hA5);
        n_checks++;
        if (RxValid !== 1'b1 || DataOut !== 8'hA5 || n_valid !== 1) begin
            n_fail++; $display("FAIL byte_a5: valid=%b data=%h cnt=%0d, expected 1/a5/1", RxValid, DataOut, n_valid);
        end
        send_byte(8'h3C);
        n_checks++;
        if (RxValid !== 1'b1 || DataOut !== 8'h3C || n_valid !== 2) begin
            n_fail++; $display("FAIL byte_3c: valid=%b data=%h cnt=%0d, expected 1/3c/2", RxValid, DataOut, n_valid);
        end
    endtask

    task automatic test_stuff_bit();
        clear_counts();
        for (int i = 0; i < 6; i++) send_bit(1'b1);
        strobe(1'b0, 1'b0, 1'b1, 1'b0);   // stuffed zero, must be dropped
        send_bit(1'b1);
        n_checks++;
        if (n_valid !== 0) begin
            n_fail++; $display("FAIL stuff_early_valid: cnt=%0d, expected 0", n_valid);
        end
        send_bit(1'b1);
        n_checks++;
        if (DataOut !== 8'hFF || n_valid !== 1) begin
            n_fail++; $display("FAIL stuff_byte_ff: data=%h cnt=%0d, expected ff/1", DataOut, n_valid);
        end
    endtask

    task automatic test_eop();
        clear_counts();
        send_se0();
        send_se0();
        n_checks++;
        if (RxActive !== 1'b1 || n_eop !== 0) begin
            n_fail++; $display("FAIL eop_before_j: active=%b eop=%0d, expected 1/0", RxActive, n_eop);
        end
        send_bit(1'b1);
        n_checks++;
        if (EOP_detected !== 1'b1 || RxActive !== 1'b0 || RxError !== 1'b0 || n_valid !== 0) begin
            n_fail++; $display("FAIL eop_good: eop=%b active=%b err=%b valid=%0d, expected 1/0/0/0",
                               EOP_detected, RxActive, RxError, n_valid);
        end
        n_checks++;
        if (rx_state !== 3'd0) begin
            n_fail++; $display("FAIL eop_idle: state=%0d, expected 0", rx_state);
        end
    endtask

    task automatic test_partial();
        clear_counts();
        send_sync();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        send_se0(); send_se0(); send_bit(1'b1);
        n_checks++;
        if (RxError !== 1'b1 || EOP_detected !== 1'b1 || n_valid !== 0 || RxActive !== 1'b0) begin
            n_fail++; $display("FAIL partial_byte: err=%b eop=%b valid=%0d active=%b, expected 1/1/0/0",
                               RxError, EOP_detected, n_valid, RxActive);
        end
    endtask

    task automatic test_dribble();
        logic exp_err;
`ifdef RX_DRIBBLE_EN
        exp_err = 1'b0;
`else
        exp_err = 1'b1;
`endif
        clear_counts();
        send_sync();
        send_byte(8'h5A);
        send_bit(1'b0);
        send_se0(); send_se0(); send_bit(1'b1);
        n_checks++;
        if (RxError !== exp_err || EOP_detected !== 1'b1 || n_valid !== 1 || DataOut !== 8'h5A) begin
            n_fail++; $display("FAIL dribble: err=%b eop=%b valid=%0d data=%h, expected %b/1/1/5a",
                               RxError, EOP_detected, n_valid, DataOut, exp_err);
        end
    endtask

    task automatic test_short_eop();
        clear_counts();
        send_sync();
        send_byte(8'hC3);
        send_se0();
        send_bit(1'b1);
        n_checks++;
        if (RxError !== 1'b1 || n_eop !== 0 || RxActive !== 1'b0 || DataOut !== 8'hC3) begin
            n_fail++; $display("FAIL short_eop: err=%b eop=%0d active=%b data=%h, expected 1/0/0/c3",
                               RxError, n_eop, RxActive, DataOut);
        end
    endtask

    task automatic test_stuff_err();
        clear_counts();
        send_sync();
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        strobe(1'b1, 1'b0, 1'b1, 1'b1);   // stuff_err together with stuff_bit
        n_checks++;
        if (RxError !== 1'b1 || RxActive !== 1'b1) begin
            n_fail++; $display("FAIL stuff_err_pulse: err=%b active=%b, expected 1/1", RxError, RxActive);
        end
        send_byte(8'h96);
        n_checks++;
        if (n_valid !== 0 || RxActive !== 1'b1 || n_err !== 1 || DataOut !== 8'hC3) begin
            n_fail++; $display("FAIL stuff_err_hold: valid=%0d active=%b errs=%0d data=%h, expected 0/1/1/c3",
                               n_valid, RxActive, n_err, DataOut);
        end
        send_se0(); send_se0(); send_bit(1'b1);
        n_checks++;
        if (EOP_detected !== 1'b1 || RxError !== 1'b0 || RxActive !== 1'b0 || n_err !== 1) begin
            n_fail++; $display("FAIL stuff_err_eop: eop=%b err=%b active=%b errs=%0d, expected 1/0/0/1",
                               EOP_detected, RxError, RxActive, n_err);
        end
    endtask

    task automatic test_se0_priority();
        clear_counts();
        send_sync();
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        send_se0();   // would have been the 8th bit
        n_checks++;
        if (n_valid !== 0 || DataOut !== 8'hC3) begin
            n_fail++; $display("FAIL se0_priority: valid=%0d data=%h, expected 0/c3", n_valid, DataOut);
        end
        send_se0(); send_bit(1'b1);
        n_checks++;
        if (RxError !== 1'b1 || EOP_detected !== 1'b1) begin
            n_fail++; $display("FAIL se0_priority_eop: err=%b eop=%b, expected 1/1", RxError, EOP_detected);
        end
    endtask

    task automatic test_enable_drop();
        clear_counts();
        send_sync();
        send_byte(8'h81);
        send_bit(1'b0); send_bit(1'b1);
        @(negedge Clk);
        rx_enable = 1'b0;
        @(posedge Clk);
        #1;
        sample();
        n_checks++;
        if (RxActive !== 1'b0 || rx_state !== 3'd0 || DataOut !== 8'h81) begin
            n_fail++; $display("FAIL enable_drop: active=%b state=%0d data=%h, expected 0/0/81",
                               RxActive, rx_state, DataOut);
        end
        idle(2);
        rx_enable = 1'b1;
        n_checks++;
        if (n_eop !== 0 || n_err !== 0 || n_valid !== 1) begin
            n_fail++; $display("FAIL enable_drop_pulses: eop=%0d err=%0d valid=%0d, expected 0/0/1",
                               n_eop, n_err, n_valid);
        end
    endtask

    task automatic test_hunt_timeout();
        for (int i = 0; i < 17; i++) send_bit(1'b0);
        n_checks++;
        if (rx_state !== 3'd1) begin
            n_fail++; $display("FAIL hunt_16: state=%0d, expected 1", rx_state);
        end
        send_bit(1'b0);
        n_checks++;
        if (rx_state !== 3'd0 || RxActive !== 1'b0) begin
            n_fail++; $display("FAIL hunt_17: state=%0d active=%b, expected 0/0", rx_state, RxActive);
        end
    endtask

    task automatic test_async_reset();
        send_sync();
        send_byte(8'hE7);
        send_bit(1'b1); send_bit(1'b0);
        #2;
        Rst = 1'b0;
        #1;
        n_checks++;
        if ({DataOut, RxValid, RxActive, sync_detected, EOP_detected, RxError} !== 13'h0 ||
            rx_state !== 3'd0) begin
            n_fail++; $display("FAIL async_reset: outs=%h state=%0d, expected 0/0",
                               {DataOut, RxValid, RxActive, sync_detected, EOP_detected, RxError}, rx_state);
        end
        @(negedge Clk);
        Rst = 1'b1;
        idle(1);
    endtask

    initial begin
        Rst = 1'b0; rx_enable = 1'b0; bit_valid = 1'b0; data_in_s = 1'b0;
        stuff_bit = 1'b0; stuff_err = 1'b0; se0 = 1'b0;
        clear_counts();
        #12;
        test_reset();
        @(negedge Clk);
        Rst = 1'b1;
        rx_enable = 1'b1;
        test_sync();
        test_bytes();
        test_stuff_bit();
        test_eop();
        test_partial();
        test_dribble();
        test_short_eop();
        test_stuff_err();
        test_se0_priority();
        test_enable_drop();
        test_hunt_timeout();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
